// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Purpose  : Execute-stage ALU. AND/OR/ADD/SUB finish one cycle after accept.
//            MUL uses an iterative radix-2 shift-add engine. A start/ready/done
//            handshake lets the hazard unit stall the pipeline while busy.
// Ports    : clk_i, rst_i      - clock, synchronous active-high reset
//            start_i           - request, accepted when ready_o=1
//            ALUCtrl_i[2:0]    - 000 AND, 001 OR, 010 ADD, 011 MUL, 110 SUB,
//                                any other code behaves as ADD
//            data1_i, data2_i  - operands (multiplicand, multiplier for MUL)
//            ready_o           - new request may be accepted this cycle
//            busy_o            - MUL iterating (pipeline stall)
//            done_o            - one-cycle pulse, data_o valid
//            data_o            - result, held until the next done_o
// Options  : MUL_EARLY_EXIT_EN - MUL stops once the remaining multiplier is 0,
//            otherwise MUL always takes WIDTH iterations.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic             last_iter;

  // Single-cycle ops; unused codes fall through to ADD.
  always_comb begin
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      default: alu_res = data1_i + data2_i;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  // The multiplier after this cycle's shift is mplier_q[WIDTH-1:1].
  assign last_iter = (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_BUSY: begin
        // start_i is deliberately ignored here: no queuing while iterating.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          data_d  = acc_step;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE lasts one cycle unless refilled.
        state_d = S_IDLE;
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            state_d  = S_BUSY;
            acc_d    = '0;
            mcand_d  = data1_i;
            mplier_d = data2_i;
            cnt_d    = '0;
          end else begin
            state_d = S_DONE;
            data_d  = alu_res;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o = (state_q != S_BUSY);
  assign busy_o  = (state_q == S_BUSY);
  assign done_o  = (state_q == S_DONE);
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec
// Purpose  : Self-checking bench for alu_exec (WIDTH=32). Expected results and
//            latencies come from plain arithmetic on the operation semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ctrl;
  logic [W-1:0] d1, d2;
  logic         ready, busy, done;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .data1_i   (d1),
    .data2_i   (d2),
    .ready_o   (ready),
    .busy_o    (busy),
    .done_o    (done),
    .data_o    (dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_res(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    longint unsigned p;
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011: begin
        p = longint'(a) * longint'(b);
        return p[W-1:0];
      end
      3'b110:  return a - b;
      default: return a + b;
    endcase
  endfunction

  // Cycles from the accept cycle to the done_o cycle.
  function automatic int model_lat(logic [2:0] op, logic [W-1:0] b);
    int n;
    if (op != 3'b011) return 1;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    n = W;
    return n + 1;
`endif
  endfunction

  // Issue one op from an idle/done cycle and wait (bounded) for done_o.
  // lat = -1 means done_o never came.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noise, output logic [W-1:0] res, output int lat,
                       output int bcnt);
    ctrl = op; d1 = a; d2 = b; start = 1'b1;
    step();
    start = 1'b0; lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        d1 = $urandom; d2 = $urandom; ctrl = 3'($urandom);
      end
      step();
      lat++;
    end
    start = 1'b0;
    res = dout;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctrl = 3'b010; d1 = '0; d2 = '0;
    step(); step();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", dout); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    logic [W-1:0] r; int lat, bc;
    do_op(3'b010, 32'd5, 32'd7, 1'b0, r, lat, bc);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got=%0d exp=1", lat); end
    n_checks++; if (r !== 32'd12) begin n_fail++; $display("FAIL add_data got=%h exp=%h", r, 32'd12); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_done got=%b exp=1", ready); end
    step();
    n_checks++; if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL add_idle got done=%b ready=%b exp done=0 ready=1", done, ready);
    end
  endtask

  task automatic test_back_to_back();
    ctrl = 3'b110; d1 = 32'd3; d2 = 32'd5; start = 1'b1;
    step();
    n_checks++; if (done !== 1'b1 || dout !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL b2b_sub got done=%b data=%h exp done=1 data=fffffffe", done, dout);
    end
    ctrl = 3'b001; d1 = 32'hF0; d2 = 32'h0F;
    step();
    n_checks++; if (done !== 1'b1 || dout !== 32'hFF) begin
      n_fail++; $display("FAIL b2b_or got done=%b data=%h exp done=1 data=ff", done, dout);
    end
    ctrl = 3'b000; d1 = 32'hFF; d2 = 32'h3C;
    step();
    n_checks++; if (done !== 1'b1 || dout !== 32'h3C) begin
      n_fail++; $display("FAIL b2b_and got done=%b data=%h exp done=1 data=3c", done, dout);
    end
    start = 1'b0;
    step();
    n_checks++; if (done !== 1'b0 || dout !== 32'h3C) begin
      n_fail++; $display("FAIL b2b_end got done=%b data=%h exp done=0 data=3c", done, dout);
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; int lat, bc;
    // All-ones squared, with start pulses and operand churn while busy.
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, lat, bc);
    n_checks++; if (lat !== model_lat(3'b011, 32'hFFFF_FFFF)) begin
      n_fail++; $display("FAIL mul_ff_latency got=%0d exp=%0d", lat, model_lat(3'b011, 32'hFFFF_FFFF));
    end
    n_checks++; if (bc !== lat - 1) begin n_fail++; $display("FAIL mul_ff_busy got=%0d exp=%0d", bc, lat - 1); end
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL mul_ff_data got=%h exp=1", r); end
    step();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mul_ff_after got done=%b busy=%b exp 0 0", done, busy);
    end
    do_op(3'b011, 32'd6, 32'd3, 1'b0, r, lat, bc);
    n_checks++; if (lat !== model_lat(3'b011, 32'd3)) begin
      n_fail++; $display("FAIL mul_6x3_latency got=%0d exp=%0d", lat, model_lat(3'b011, 32'd3));
    end
    n_checks++; if (r !== 32'd18) begin n_fail++; $display("FAIL mul_6x3_data got=%h exp=12", r); end
    step();
    do_op(3'b011, 32'd100, 32'd0, 1'b0, r, lat, bc);
    n_checks++; if (lat !== model_lat(3'b011, 32'd0)) begin
      n_fail++; $display("FAIL mul_100x0_latency got=%0d exp=%0d", lat, model_lat(3'b011, 32'd0));
    end
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL mul_100x0_data got=%h exp=0", r); end
    step();
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] r; int lat, bc; int seen;
    do_op(3'b010, 32'h1234, 32'h1, 1'b0, r, lat, bc);
    step();
    ctrl = 3'b011; d1 = 32'hFFFF_FFFF; d2 = 32'hFFFF_FFFF; start = 1'b1;
    step();                       // now in T+1
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();   // now in T+10
    rst = 1'b1; start = 1'b1; ctrl = 3'b010;
    step();                       // T+11
    rst = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1 || dout !== '0) begin
      n_fail++; $display("FAIL abort_state got busy=%b done=%b ready=%b data=%h exp 0 0 1 0",
                         busy, done, ready, dout);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
    logic [2:0] op; logic [W-1:0] a, b, r; int lat, bc;
    for (int k = 0; k < 40; k++) begin
      op = (k % 3 == 0) ? 3'b011 : ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      do_op(op, a, b, (op == 3'b011), r, lat, bc);
      n_checks++; if (r !== model_res(op, a, b)) begin
        n_fail++; $display("FAIL rand_data op=%b a=%h b=%h got=%h exp=%h", op, a, b, r, model_res(op, a, b));
      end
      n_checks++; if (lat !== model_lat(op, b)) begin
        n_fail++; $display("FAIL rand_latency op=%b b=%h got=%0d exp=%0d", op, b, lat, model_lat(op, b));
      end
      if (op == 3'b011) begin
        n_checks++; if (bc !== lat - 1) begin
          n_fail++; $display("FAIL rand_busy got=%0d exp=%0d", bc, lat - 1);
        end
      end
      step();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rand_single_pulse got=%b exp=0", done); end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
